// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding and Booth pair codes.
package booth_mult_seq_pkg;

  localparam int BOOTH_N     = 8;
  localparam int BOOTH_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // {Q[0], q_1} recoding: 01 adds M, 10 subtracts M, 00/11 only shift.
  typedef enum logic [1:0] {
    BP_NOP0 = 2'b00,
    BP_ADD  = 2'b01,
    BP_SUB  = 2'b10,
    BP_NOP1 = 2'b11
  } bpair_t;

endpackage

// File: rtl/booth_mult_seq_rcas8.sv
// RCAS8: 8-bit ripple-carry adder/subtractor. i_mode=1 computes i_a1 - i_a2
// as i_a1 + ~i_a2 + 1; o_carry is the carry out of bit 7.
module booth_mult_seq_rcas8 (
  input  logic [7:0] i_a1,
  input  logic [7:0] i_a2,
  input  logic       i_mode,
  output logic [7:0] o_sum,
  output logic       o_carry
);

  logic [8:0] w_c;
  logic [7:0] w_b;

  always_comb begin
    w_c    = '0;
    w_b    = '0;
    o_sum  = '0;
    w_c[0] = i_mode;
    for (int i = 0; i < 8; i++) begin
      w_b[i]   = i_a2[i] ^ i_mode;
      o_sum[i] = i_a1[i] ^ w_b[i] ^ w_c[i];
      w_c[i+1] = (i_a1[i] & w_b[i]) | (i_a1[i] & w_c[i]) | (w_b[i] & w_c[i]);
    end
  end

  assign o_carry = w_c[8];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one iteration per clock, start/busy/done
// handshake. Every add/sub step goes through the RCAS8 instance.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int N     = BOOTH_N,
  parameter int CNT_W = BOOTH_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     mcand,
  input  logic [N-1:0]     mplier,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  state_t             r_state;
  state_t             w_next;
  logic [N:0]         r_a;
  logic [N-1:0]       r_q;
  logic [N-1:0]       r_m;
  logic               r_q1;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*N-1:0]     r_product;

  logic               w_load;
  logic               w_step;
  logic               w_last;
  bpair_t             w_pair;
  logic               w_mode;
  logic               w_arith;
  logic [N-1:0]       w_add_sum;
  logic               w_carry;
  logic [N:0]         w_sum;
  logic [N:0]         w_a_next;
  logic [N-1:0]       w_q_next;

  assign w_pair  = bpair_t'({r_q[0], r_q1});
  assign w_mode  = (w_pair == BP_SUB);
  assign w_arith = (w_pair == BP_ADD) || (w_pair == BP_SUB);

  booth_mult_seq_rcas8 u_rcas8 (
    .i_a1    (r_a[N-1:0]),
    .i_a2    (r_m),
    .i_mode  (w_mode),
    .o_sum   (w_add_sum),
    .o_carry (w_carry)
  );

  // Ninth sum bit rebuilt from the 8-bit carry so -128 subtract steps stay exact.
  assign w_sum    = w_arith ? {r_a[N] ^ (r_m[N-1] ^ w_mode) ^ w_carry, w_add_sum} : r_a;
  assign w_a_next = {w_sum[N], w_sum[N:1]};
  assign w_q_next = {w_sum[0], r_q[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_m   <= mcand;
      r_q   <= mplier;
      r_a   <= '0;
      r_q1  <= 1'b0;
      r_cnt <= CNT_W'(N);
    end else if (w_step) begin
      r_a   <= w_a_next;
      r_q   <= w_q_next;
      r_q1  <= r_q[0];
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) r_product <= {w_a_next[N-1:0], w_q_next};
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: handshake timing, sign/corner products,
// start while busy, back-to-back, mid-run reset and a sampled operand sweep.
module tb_booth_mult_seq;

  localparam int N = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic [N-1:0]    mcand;
  logic [N-1:0]    mplier;
  logic            busy;
  logic            done;
  logic [2*N-1:0]  product;

  int errors;
  int checks;

  booth_mult_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: presents one start, returns at the negedge where done
  // is seen. edges counts rising edges from the sampling edge; -1 on timeout.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int edges, output logic first_busy);
    start      = 1'b1;
    mcand      = a;
    mplier     = b;
    edges      = -1;
    first_busy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (k == 1) first_busy = busy;
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, product} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b product=%h, want 0/0/0000", busy, done, product);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e; logic fb;
    run_op(8'd3, 8'd2, e, fb);
    checks++;
    if (e !== N + 1) begin errors++; $display("FAIL basic_latency: got %0d edges, want %0d", e, N + 1); end
    checks++;
    if (product !== 16'h0006) begin errors++; $display("FAIL basic_product: got %h want 0006", product); end
    checks++;
    if (busy !== 1'b0 || fb !== 1'b1) begin
      errors++; $display("FAIL basic_busy: got busy_in_done=%b busy_after_start=%b, want 0/1", busy, fb);
    end
  endtask

  task automatic test_signs();
    int e; logic fb;
    run_op(8'd5, 8'hFD, e, fb);
    checks++;
    if (product !== 16'hFFF1) begin errors++; $display("FAIL sign_5x-3: got %h want fff1", product); end
    run_op(8'hF9, 8'hF7, e, fb);
    checks++;
    if (product !== 16'h003F) begin errors++; $display("FAIL sign_-7x-9: got %h want 003f", product); end
  endtask

  task automatic test_corners();
    logic [7:0]  ca [4] = '{8'h80, 8'h80, 8'h00, 8'h7F};
    logic [7:0]  cb [4] = '{8'h80, 8'h7F, 8'hFF, 8'h7F};
    logic [15:0] ce [4] = '{16'h4000, 16'hC080, 16'h0000, 16'h3F01};
    int e; logic fb;
    for (int i = 0; i < 4; i++) begin
      run_op(ca[i], cb[i], e, fb);
      checks++;
      if (product !== ce[i] || e !== N + 1) begin
        errors++;
        $display("FAIL corner_%0d: got %h after %0d edges, want %h after %0d", i, product, e, ce[i], N + 1);
      end
    end
  endtask

  task automatic test_start_held();
    int pulses;
    logic saw_busy;
    pulses = 0; saw_busy = 1'b0;
    start = 1'b1; mcand = 8'd10; mplier = 8'd11;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 3) begin
        mcand  = mcand + 8'd37;
        mplier = mplier - 8'd53;
      end else begin
        start = 1'b0;
      end
      if (k == 2) saw_busy = busy;
      if (done) pulses++;
    end
    checks++;
    if (product !== 16'h006E) begin errors++; $display("FAIL held_product: got %h want 006e", product); end
    checks++;
    if (pulses !== 1 || saw_busy !== 1'b1) begin
      errors++; $display("FAIL held_done_pulses: got %0d pulses busy=%b, want 1 pulse busy=1", pulses, saw_busy);
    end
  endtask

  task automatic test_back_to_back();
    int e; logic fb;
    run_op(8'd6, 8'd7, e, fb);
    checks++;
    if (product !== 16'h002A) begin errors++; $display("FAIL b2b_first: got %h want 002a", product); end
    run_op(8'd2, 8'd2, e, fb);
    checks++;
    if (fb !== 1'b1 || e !== N + 1) begin
      errors++; $display("FAIL b2b_timing: got busy=%b edges=%0d, want busy=1 edges=%0d", fb, e, N + 1);
    end
    checks++;
    if (product !== 16'h0004) begin errors++; $display("FAIL b2b_second: got %h want 0004", product); end
  endtask

  task automatic test_reset_mid_run();
    int e; logic fb;
    start = 1'b1; mcand = 8'd7; mplier = 8'd7;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, product} !== 18'd0) begin
      errors++;
      $display("FAIL midrst_clear: got busy=%b done=%b product=%h, want 0/0/0000", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd7, 8'd7, e, fb);
    checks++;
    if (product !== 16'h0031 || e !== N + 1) begin
      errors++; $display("FAIL midrst_rerun: got %h after %0d edges, want 0031 after %0d", product, e, N + 1);
    end
  endtask

  task automatic test_sweep();
    logic [7:0]  sv [5] = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};
    logic [7:0]  a, b;
    logic [15:0] exp_p;
    int e; logic fb;
    for (int i = 0; i < 125; i++) begin
      if (i < 25) begin
        a = sv[i / 5];
        b = sv[i % 5];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      exp_p = 16'($signed(a) * $signed(b));
      run_op(a, b, e, fb);
      checks++;
      if (product !== exp_p || e !== N + 1) begin
        errors++;
        $display("FAIL sweep %h x %h: got %h after %0d edges, want %h", a, b, product, e, exp_p);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_signs();
    test_corners();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
